// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the SRAM responder.
// Holds burst/response encodings, field typedefs, the per-transaction
// context record and the responder FSM state encoding.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef logic [3:0] axi_len_t;
  typedef logic [2:0] axi_size_t;
  typedef logic [1:0] axi_burst_t;
  typedef logic [3:0] axi_id_t;

  // Everything latched at the address handshake plus the running beat state.
  typedef struct packed {
    axi_id_t     id;
    logic [31:0] addr;
    axi_len_t    len;
    axi_size_t   size;
    axi_burst_t  burst;
    axi_len_t    count;
    logic        err;    // write-side wlast mismatch seen
  } axi_burst_ctx_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_BRESP = 2'd3
  } resp_state_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI3 burst address stepper and legality check.
// Ports:
//   addr, len, size, burst : current beat address and burst attributes
//   next_addr              : address of the following beat
//   illegal                : size wider than the 32-bit bus, or WRAP with a
//                            length other than 2/4/8/16 beats
module axi_burst_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [3:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        illegal
);

  logic [31:0] step;
  logic [31:0] mask;
  logic [31:0] incr;

  always_comb begin
    step = 32'd1 << size;
    // Wrap boundary is the total burst size in bytes.
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    incr = addr + step;
    illegal = (size > 3'd2) ||
              ((burst == AXI_BURST_WRAP) &&
               !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    case (burst)
      AXI_BURST_FIXED: next_addr = addr;
      AXI_BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:         next_addr = incr;   // INCR and reserved 2'b11
    endcase
  end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 slave serving AR/R and AW/W/B bursts from an internal word SRAM.
// One transaction at a time; reads win over simultaneous writes in IDLE.
// Ports:
//   aclk, areset            : clock, synchronous active-high reset
//   ar*/r*                  : read address / read data channels
//   aw*/w*/b*               : write address / data / response channels
//   arlock..awprot, wid     : accepted and ignored
//   dbg_state               : current FSM state (resp_state_t encoding)
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid && ready are both high; a source holds its payload stable while
// valid is high and ready is low, and this block never withdraws rvalid or
// bvalid before the transfer.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int MEM_AW    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  dbg_state
);

  logic [31:0] mem [0:(2**MEM_AW)-1];

  resp_state_t     state, state_d;
  axi_burst_ctx_t  ctx, ctx_d;
  logic [31:0]     next_addr;
  logic            illegal;
  logic            mem_we;
  logic [MEM_AW-1:0] idx;

  logic unused_inputs;
  assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

  assign idx       = ctx.addr[MEM_AW+1:2];
  assign dbg_state = state;

  axi_burst_addr_gen u_addr_gen (
    .addr      (ctx.addr),
    .len       (ctx.len),
    .size      (ctx.size),
    .burst     (ctx.burst),
    .next_addr (next_addr),
    .illegal   (illegal)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= ST_IDLE;
      ctx   <= '0;
    end else begin
      state <= state_d;
      ctx   <= ctx_d;
    end
  end

  // No reset on the array: contents survive areset.
  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state;
    ctx_d   = ctx;
    arready = 1'b0;
    awready = 1'b0;
    rvalid  = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = AXI_RESP_OKAY;
    rlast   = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bid     = '0;
    bresp   = AXI_RESP_OKAY;
    mem_we  = 1'b0;
    case (state)
      ST_IDLE: begin
        // Readies are held low while reset is asserted.
        arready = !areset;
        awready = !areset && !arvalid;
        if (arvalid) begin
          ctx_d = '{id: arid, addr: araddr, len: arlen, size: arsize,
                    burst: arburst, count: '0, err: 1'b0};
          state_d = ST_READ;
        end else if (awvalid) begin
          ctx_d = '{id: awid, addr: awaddr, len: awlen, size: awsize,
                    burst: awburst, count: '0, err: 1'b0};
          state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        rvalid = 1'b1;
        rid    = ctx.id;
        rlast  = (ctx.count == ctx.len);
        rresp  = illegal ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rdata  = illegal ? 32'd0 : mem[idx];
        if (rready) begin
          ctx_d.addr  = next_addr;
          ctx_d.count = ctx.count + 4'd1;
          if (rlast) state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we      = !areset && !illegal;
          ctx_d.addr  = next_addr;
          ctx_d.count = ctx.count + 4'd1;
          if (wlast != (ctx.count == ctx.len)) ctx_d.err = 1'b1;
          // Burst length comes from awlen; wlast only feeds the error flag.
          if (ctx.count == ctx.len) state_d = ST_BRESP;
        end
      end
      ST_BRESP: begin
        bvalid = 1'b1;
        bid    = ctx.id;
        bresp  = (ctx.err || illegal) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: a table of burst transactions with their
// expected responses, applied in order through AXI driver tasks, plus
// hand-written sequences for reset, backpressure, arbitration and
// reset-in-burst corner cases.
module tb_axi_sram_responder;
  import axi_pkg::*;

  logic        aclk, areset;
  logic [3:0]  arid;   logic [31:0] araddr; logic [3:0] arlen;
  logic [2:0]  arsize; logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;    logic [31:0] rdata;  logic [1:0] rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid;   logic [31:0] awaddr; logic [3:0] awlen;
  logic [2:0]  awsize; logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;    logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [1:0]  dbg_state;

  axi_sram_responder dut (
    .aclk(aclk), .areset(areset),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(2'b00), .arcache(4'h0), .arprot(3'h0),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(2'b00), .awcache(4'h0), .awprot(3'h0),
    .awvalid(awvalid), .awready(awready),
    .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [38:0] exp_q[$];    // {id, data, resp, last} per R beat
  logic [5:0]  exp_b_q[$];  // {id, resp} per B

  typedef struct packed {
    logic             is_wr;
    logic             bad;     // assert wlast on beat 0 instead of last beat
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       strb;
    logic [1:0]       resp;
    logic [3:0][31:0] d;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(logic wr, logic bad, logic [3:0] id,
                              logic [31:0] addr, logic [3:0] len,
                              logic [2:0] size, logic [1:0] burst,
                              logic [3:0] strb, logic [1:0] resp,
                              logic [127:0] d);
    vec_t v;
    v.is_wr = wr;  v.bad = bad;   v.id = id;     v.addr = addr;
    v.len = len;   v.size = size; v.burst = burst;
    v.strb = strb; v.resp = resp; v.d = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tmo(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got no handshake, expected one within 200 cycles", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    int t = 0;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arvalid = 1'b1;
    do begin @(negedge aclk); t++; end while (!arready && t < 200);
    if (!arready) tmo("ar_handshake");
    else chk("rvalid_low_in_ar_cycle", 64'(rvalid), 64'd0);
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic collect_r(input int nbeats);
    int got = 0;
    int t = 0;
    logic [38:0] e;
    while (got < nbeats && t < 200) begin
      rready = ($urandom_range(0, 3) != 0);
      @(negedge aclk); t++;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          chk("r_unexpected_beat", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(e));
        end
        got++;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    if (got < nbeats) tmo("r_beats");
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr,
                       input logic [3:0] len, input logic [2:0] size,
                       input logic [1:0] burst);
    int t = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    do begin @(negedge aclk); t++; end while (!awready && t < 200);
    if (!awready) tmo("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [3:0] len, input logic [3:0] strb,
                        input logic bad, input logic [3:0][31:0] d);
    for (int b = 0; b <= int'(len); b++) begin
      int t = 0;
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = d[b]; wstrb = strb;
      wlast  = bad ? (b == 0) : (b == int'(len));
      do begin @(negedge aclk); t++; end while (!wready && t < 200);
      if (!wready) tmo("w_handshake");
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic get_b();
    int t = 0;
    logic [5:0] e;
    repeat ($urandom_range(0, 2)) @(posedge aclk);
    #1;
    bready = 1'b1;
    do begin @(negedge aclk); t++; end while (!bvalid && t < 200);
    if (!bvalid) tmo("b_handshake");
    else begin
      e = exp_b_q.pop_front();
      chk("b_resp", 64'({bid, bresp}), 64'(e));
    end
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    if (v.is_wr) begin
      do_aw(v.id, v.addr, v.len, v.size, v.burst);
      send_w(v.len, v.strb, v.bad, v.d);
      exp_b_q.push_back({v.id, v.resp});
      get_b();
    end else begin
      for (int i = 0; i <= int'(v.len); i++)
        exp_q.push_back({v.id, v.d[i], v.resp, (i == int'(v.len))});
      do_ar(v.id, v.addr, v.len, v.size, v.burst);
      collect_r(int'(v.len) + 1);
    end
  endtask

  function automatic logic [49:0] all_out();
    return {arready, awready, wready, rvalid, rid, rdata, rresp, rlast,
            bvalid, bid, bresp};
  endfunction

  function automatic logic [39:0] r_bus();
    return {rvalid, rid, rdata, rresp, rlast};
  endfunction

  // ---------------- test ----------------
  initial begin
    areset = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;

    vecs[0]  = mk(1'b1, 1'b0, 4'd3, 32'h100, 4'd3, 3'd2, AXI_BURST_INCR, 4'hF, AXI_RESP_OKAY,
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    vecs[1]  = mk(1'b0, 1'b0, 4'd5, 32'h100, 4'd3, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    vecs[2]  = mk(1'b0, 1'b0, 4'd6, 32'h10C, 4'd3, 3'd2, AXI_BURST_WRAP, 4'h0, AXI_RESP_OKAY,
                  {32'hA2, 32'hA1, 32'hA0, 32'hA3});
    vecs[3]  = mk(1'b1, 1'b0, 4'd7, 32'h100, 4'd0, 3'd2, AXI_BURST_INCR, 4'h2, AXI_RESP_OKAY,
                  {96'd0, 32'h0000BB00});
    vecs[4]  = mk(1'b0, 1'b0, 4'd1, 32'h100, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {96'd0, 32'h0000BBA0});
    vecs[5]  = mk(1'b1, 1'b1, 4'd2, 32'h200, 4'd1, 3'd2, AXI_BURST_INCR, 4'hF, AXI_RESP_SLVERR,
                  {64'd0, 32'h22, 32'h11});
    vecs[6]  = mk(1'b0, 1'b0, 4'd4, 32'h200, 4'd1, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {64'd0, 32'h22, 32'h11});
    vecs[7]  = mk(1'b0, 1'b0, 4'd8, 32'h100, 4'd1, 3'd3, AXI_BURST_INCR, 4'h0, AXI_RESP_SLVERR,
                  128'd0);
    vecs[8]  = mk(1'b0, 1'b0, 4'd9, 32'h104, 4'd2, 3'd2, AXI_BURST_FIXED, 4'h0, AXI_RESP_OKAY,
                  {32'd0, 32'hA1, 32'hA1, 32'hA1});
    vecs[9]  = mk(1'b1, 1'b0, 4'hA, 32'h300, 4'd2, 3'd2, AXI_BURST_WRAP, 4'hF, AXI_RESP_SLVERR,
                  {32'd0, 32'h3, 32'h2, 32'h1});
    vecs[10] = mk(1'b0, 1'b0, 4'hB, 32'h100, 4'd2, 3'd2, AXI_BURST_WRAP, 4'h0, AXI_RESP_SLVERR,
                  128'd0);
    vecs[11] = mk(1'b1, 1'b0, 4'hC, 32'h1040, 4'd0, 3'd2, AXI_BURST_INCR, 4'hF, AXI_RESP_OKAY,
                  {96'd0, 32'h5A5A5A5A});
    vecs[12] = mk(1'b0, 1'b0, 4'hD, 32'h40, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {96'd0, 32'h5A5A5A5A});
    vecs[13] = mk(1'b1, 1'b0, 4'hE, 32'hFFFFFFFC, 4'd1, 3'd2, AXI_BURST_INCR, 4'hF, AXI_RESP_OKAY,
                  {64'd0, 32'hC1, 32'hC0});
    vecs[14] = mk(1'b0, 1'b0, 4'hF, 32'h0, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {96'd0, 32'hC1});
    vecs[15] = mk(1'b0, 1'b0, 4'h0, 32'hFFC, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {96'd0, 32'hC0});
    vecs[16] = mk(1'b0, 1'b0, 4'h3, 32'h200, 4'd1, 3'd2, 2'b11, 4'h0, AXI_RESP_OKAY,
                  {64'd0, 32'h22, 32'h11});
    vecs[17] = mk(1'b0, 1'b0, 4'h6, 32'h104, 4'd1, 3'd2, AXI_BURST_WRAP, 4'h0, AXI_RESP_OKAY,
                  {64'd0, 32'h0000BBA0, 32'hA1});
    vecs[18] = mk(1'b0, 1'b0, 4'h2, 32'h10C, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
                  {96'd0, 32'hA3});

    // Reset and idle outputs.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("outputs_in_reset", 64'(all_out()), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      chk("outputs_idle", 64'(all_out()), 64'({1'b1, 1'b1, 48'd0}));
      chk("state_idle", 64'(dbg_state), 64'(ST_IDLE));
    end
    @(posedge aclk); #1;

    // Table of bursts.
    for (int k = 0; k < 19; k++) run_vec(vecs[k]);

    // WRAP read with a 3-cycle stall after beat 0; checks first-beat latency.
    do_ar(4'd6, 32'h10C, 4'd3, 3'd2, AXI_BURST_WRAP);
    rready = 1'b1;
    @(negedge aclk);
    chk("stall_beat0", 64'(r_bus()), 64'({1'b1, 4'd6, 32'hA3, 2'b00, 1'b0}));
    @(posedge aclk); #1;
    rready = 1'b0;
    repeat (3) begin
      @(negedge aclk);
      chk("stall_hold", 64'(r_bus()), 64'({1'b1, 4'd6, 32'h0000BBA0, 2'b00, 1'b0}));
      @(posedge aclk); #1;
    end
    rready = 1'b1;
    @(negedge aclk);
    chk("stall_beat1", 64'(r_bus()), 64'({1'b1, 4'd6, 32'h0000BBA0, 2'b00, 1'b0}));
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("stall_beat2", 64'(r_bus()), 64'({1'b1, 4'd6, 32'hA1, 2'b00, 1'b0}));
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("stall_beat3", 64'(r_bus()), 64'({1'b1, 4'd6, 32'hA2, 2'b00, 1'b1}));
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    chk("stall_done", 64'(rvalid), 64'd0);
    @(posedge aclk); #1;

    // Simultaneous AR and AW: read first, write in the following IDLE.
    arid = 4'd1; araddr = 32'h104; arlen = 4'd0; arsize = 3'd2;
    arburst = AXI_BURST_INCR; arvalid = 1'b1;
    awid = 4'd2; awaddr = 32'h108; awlen = 4'd0; awsize = 3'd2;
    awburst = AXI_BURST_INCR; awvalid = 1'b1;
    @(negedge aclk);
    chk("arb_ready", 64'({arready, awready}), 64'(2'b10));
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge aclk);
    chk("arb_aw_blocked", 64'(awready), 64'd0);
    chk("arb_read_beat", 64'(r_bus()), 64'({1'b1, 4'd1, 32'hA1, 2'b00, 1'b1}));
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    chk("arb_aw_accept", 64'(awready), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wlast = 1'b1;
    @(negedge aclk);
    chk("arb_wready", 64'(wready), 64'd1);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge aclk);
    chk("arb_b", 64'({bvalid, bid, bresp}), 64'({1'b1, 4'd2, 2'b00}));
    @(posedge aclk); #1;
    bready = 1'b0;
    run_vec(mk(1'b0, 1'b0, 4'd2, 32'h108, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
               {96'd0, 32'h77}));

    // Reset during read beat 1 abandons the burst.
    do_ar(4'd9, 32'h100, 4'd3, 3'd2, AXI_BURST_INCR);
    rready = 1'b1;
    @(negedge aclk);
    chk("rst_beat0", 64'(r_bus()), 64'({1'b1, 4'd9, 32'h0000BBA0, 2'b00, 1'b0}));
    @(posedge aclk); #1;
    rready = 1'b0;
    @(negedge aclk);
    chk("rst_beat1", 64'(r_bus()), 64'({1'b1, 4'd9, 32'hA1, 2'b00, 1'b0}));
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("rst_outputs", 64'(all_out()), 64'({1'b1, 1'b1, 48'd0}));
    @(posedge aclk); #1;
    // Memory survives reset.
    run_vec(mk(1'b0, 1'b0, 4'd4, 32'h100, 4'd0, 3'd2, AXI_BURST_INCR, 4'h0, AXI_RESP_OKAY,
               {96'd0, 32'h0000BBA0}));

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("exp_b_q_drained", 64'(exp_b_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
